// File: rtl/data_sync_pkg.sv
// Shared types and helpers for the source-side launcher of the DATA_SYNC crossing.
package data_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    GAP   = 2'd3
  } tx_state_e;

  // Width of a down-counter able to hold max(hold, gap) - 1; never narrower than 1 bit.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/data_sync_tx.sv
// Source-side launcher: registers a word onto unsync_bus, then raises bus_enable with
// set-up/hold/gap timing (timed mode) or a four-phase handshake on ack_sync (ack mode).
module data_sync_tx
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int USE_ACK     = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ack_sync,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 tx_done
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] bus_d;
  logic                 en_d;
  logic                 done_d;

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = unsync_bus;
    en_d    = bus_enable;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (in_valid) begin
          bus_d   = in_data;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = REQ;
        en_d    = 1'b1;
        cnt_d   = HOLD_LOAD;
      end
      REQ: begin
        if (USE_ACK != 0) begin
          if (ack_sync) begin
            state_d = GAP;
            en_d    = 1'b0;
          end
        end else if (cnt_q == '0) begin
          state_d = GAP;
          en_d    = 1'b0;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        // Leaving GAP is the completion point; tx_done marks the return to IDLE.
        if (USE_ACK != 0) begin
          if (!ack_sync) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      unsync_bus <= bus_d;
      bus_enable <= en_d;
      tx_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: a timed-mode instance (H=3, G=2) and an ack-mode instance.
module tb_data_sync_tx;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         t_valid = 1'b0, t_ack = 1'b0, t_rdy, t_en, t_done;
  logic [W-1:0] t_data = '0, t_bus;
  logic         a_valid = 1'b0, a_ack = 1'b0, a_rdy, a_en, a_done;
  logic [W-1:0] a_data = '0, a_bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sync_tx #(.BUS_WIDTH(W), .HOLD_CYCLES(3), .GAP_CYCLES(2), .USE_ACK(0)) tdut (
    .CLK(clk), .RST(rst_n), .in_data(t_data), .in_valid(t_valid), .in_ready(t_rdy),
    .ack_sync(t_ack), .unsync_bus(t_bus), .bus_enable(t_en), .tx_done(t_done)
  );

  data_sync_tx #(.BUS_WIDTH(W), .HOLD_CYCLES(2), .GAP_CYCLES(2), .USE_ACK(1)) adut (
    .CLK(clk), .RST(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
    .ack_sync(a_ack), .unsync_bus(a_bus), .bus_enable(a_en), .tx_done(a_done)
  );

  // Behavioural stand-in for the destination synchronizer on the timed instance.
  logic         s1, s2, s3;
  logic [W-1:0] dst_data;
  int           pulses;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0; dst_data <= '0; pulses <= 0;
    end else begin
      s1 <= t_en; s2 <= s1; s3 <= s2;
      if (s2 && !s3) begin
        pulses   <= pulses + 1;
        dst_data <= t_bus;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         en;
    logic [W-1:0] bus;
    logic         done;
    logic         rdy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int acc0, acc1, n_acc, n_done, en_chg, hi, got_done;
    logic [W-1:0] prev;

    //            v     d     en    bus   done  rdy
    tbl[0]  = '{1'b1, 4'hB, 1'b0, 4'hB, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'h0, 1'b1, 4'hB, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 1'b1, 4'hB, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 1'b1, 4'hB, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 4'h0, 1'b0, 4'hB, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'h6, 1'b0, 4'h6, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'hF, 1'b1, 4'h6, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'hF, 1'b1, 4'h6, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'hF, 1'b1, 4'h6, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'hF, 1'b0, 4'h6, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'h0, 1'b0, 4'h6, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 1'b1};

    // Reset values
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_bus_enable", t_en, 1'b0);
    chk("rst_unsync_bus", t_bus, 4'h0);
    chk("rst_tx_done", t_done, 1'b0);
    chk("rst_in_ready", t_rdy, 1'b1);
    chk("rst_ack_in_ready", a_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Timed single transfer followed by a transfer with ignored in_valid
    for (int i = 0; i < 16; i++) begin
      t_valid = tbl[i].v;
      t_data  = tbl[i].d;
      step();
      chk($sformatf("tbl[%0d].bus_enable", i), t_en, tbl[i].en);
      chk($sformatf("tbl[%0d].unsync_bus", i), t_bus, tbl[i].bus);
      chk($sformatf("tbl[%0d].tx_done", i), t_done, tbl[i].done);
      chk($sformatf("tbl[%0d].in_ready", i), t_rdy, tbl[i].rdy);
      if (i == 7) begin
        chk("dst_pulses_first", pulses, 1);
        chk("dst_data_first", dst_data, 4'hB);
      end
    end
    t_valid = 1'b0;
    chk("dst_pulses_total", pulses, 2);
    chk("dst_data_second", dst_data, 4'h6);

    // Back-to-back with in_valid held high
    acc0 = -1; acc1 = -1; n_acc = 0; n_done = 0; en_chg = 0;
    prev = t_bus;
    for (int c = 0; c < 40 && n_done < 2; c++) begin
      t_valid = (n_acc < 2);
      t_data  = (n_acc == 0) ? 4'h3 : 4'hC;
      if (t_valid && t_rdy) begin
        if (n_acc == 0) acc0 = c;
        else acc1 = c;
        n_acc++;
      end
      step();
      if (t_bus !== prev && t_en) en_chg++;
      prev = t_bus;
      if (t_done) n_done++;
    end
    t_valid = 1'b0;
    chk("b2b_accept_spacing", acc1 - acc0, 7);
    chk("b2b_tx_done_count", n_done, 2);
    chk("b2b_bus_change_while_enabled", en_chg, 0);
    chk("b2b_last_word", t_bus, 4'hC);

    // Ack mode
    a_ack = 1'b1;
    step();
    chk("ack_idle_in_ready", a_rdy, 1'b1);
    chk("ack_idle_bus_enable", a_en, 1'b0);
    a_ack = 1'b0;
    a_valid = 1'b1;
    a_data = 4'h5;
    step();
    a_valid = 1'b0;
    chk("ack_unsync_bus", a_bus, 4'h5);
    step();
    chk("ack_enable_rise", a_en, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("ack_hold_%0d", k), a_en, 1'b1);
    end
    a_ack = 1'b1;
    step();
    chk("ack_enable_fall", a_en, 1'b0);
    chk("ack_no_early_done", a_done, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("ack_gap_enable_%0d", k), a_en, 1'b0);
      chk($sformatf("ack_gap_ready_%0d", k), a_rdy, 1'b0);
      chk($sformatf("ack_gap_done_%0d", k), a_done, 1'b0);
    end
    a_ack = 1'b0;
    step();
    chk("ack_tx_done", a_done, 1'b1);
    chk("ack_back_idle", a_rdy, 1'b1);
    step();
    chk("ack_tx_done_one_cycle", a_done, 1'b0);

    // Reset during REQ
    t_valid = 1'b1;
    t_data = 4'h9;
    step();
    t_valid = 1'b0;
    step();
    step();
    chk("mid_req_enable_before_reset", t_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_enable", t_en, 1'b0);
    chk("mid_rst_unsync_bus", t_bus, 4'h0);
    chk("mid_rst_in_ready", t_rdy, 1'b1);
    chk("mid_rst_tx_done", t_done, 1'b0);
    step();
    step();
    chk("mid_rst_held_enable", t_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    t_valid = 1'b1;
    t_data = 4'h6;
    step();
    t_valid = 1'b0;
    hi = 0;
    got_done = 0;
    for (int c = 0; c < 20 && got_done == 0; c++) begin
      step();
      if (t_en) hi++;
      if (t_done) got_done = 1;
    end
    chk("post_rst_done", got_done, 1);
    chk("post_rst_enable_cycles", hi, 3);
    chk("post_rst_unsync_bus", t_bus, 4'h6);
    repeat (3) step();
    chk("post_rst_dst_pulses", pulses, 1);
    chk("post_rst_dst_data", dst_data, 4'h6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
